// File: rtl/anim_pkg.sv
// Shared animation IDs, scheduler states and default sequencing constants
// for the pet sprite animation path.
package anim_pkg;

  localparam logic [1:0] ANIM_IDLE  = 2'd0;
  localparam logic [1:0] ANIM_FEED  = 2'd1;
  localparam logic [1:0] ANIM_PLAY  = 2'd2;
  localparam logic [1:0] ANIM_SLEEP = 2'd3;

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  localparam int FRAMES_DEF     = 16;
  localparam int LOOPS_DEF      = 2;
  localparam int IDLE_LOOPS_DEF = 8;

endpackage

// File: rtl/prio_pick3.sv
// Fixed-priority pick over the three request bits: sleep > play > feed.
// Returns the winning animation ID and the one-hot bit to clear from the queue.
module prio_pick3
  import anim_pkg::*;
(
  input  logic [2:0] cand,
  output logic [1:0] anim_id,
  output logic [2:0] clear,
  output logic       valid
);

  // NOTE: every output gets a default before the if-chain so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    anim_id = ANIM_IDLE;
    clear   = 3'b000;
    valid   = 1'b0;
    if (cand[2]) begin
      anim_id = ANIM_SLEEP;
      clear   = 3'b100;
      valid   = 1'b1;
    end else if (cand[1]) begin
      anim_id = ANIM_PLAY;
      clear   = 3'b010;
      valid   = 1'b1;
    end else if (cand[0]) begin
      anim_id = ANIM_FEED;
      clear   = 3'b001;
      valid   = 1'b1;
    end
  end

endmodule

// File: rtl/anim_scheduler.sv
// Chooses which pet animation plays and drives its frame step; queues game
// requests, loops idle, and self-requests sleep after a long idle stretch.
module anim_scheduler
  import anim_pkg::*;
#(
  parameter int FRAMES     = FRAMES_DEF,
  parameter int STEP_W     = 4,
  parameter int LOOPS      = LOOPS_DEF,
  parameter int IDLE_LOOPS = IDLE_LOOPS_DEF
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic              pause,
  output logic [1:0]        anim_sel,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic [2:0]        pending
);

  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam int IDLE_W = (IDLE_LOOPS > 1) ? $clog2(IDLE_LOOPS) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LOOPS - 1);

  state_e             state_q, state_d;
  logic [1:0]         anim_q, anim_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [2:0]         pending_q, pending_d;
  logic               done_q, done_d;

  logic [2:0] cand;
  logic [1:0] pick_anim;
  logic [2:0] pick_clear;
  logic       pick_valid;
  logic       last_step;

  assign cand      = pending_q | req;
  assign last_step = (step_q == STEP_LAST);

  prio_pick3 u_pick (
    .cand    (cand),
    .anim_id (pick_anim),
    .clear   (pick_clear),
    .valid   (pick_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      anim_q    <= ANIM_IDLE;
      step_q    <= '0;
      loop_q    <= '0;
      idle_q    <= '0;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      anim_q    <= anim_d;
      step_q    <= step_d;
      loop_q    <= loop_d;
      idle_q    <= idle_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    anim_d    = anim_q;
    step_d    = step_q;
    loop_d    = loop_q;
    idle_d    = idle_q;
    pending_d = cand;
    done_d    = 1'b0;

    if (!pause) begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            state_d   = S_PLAY;
            anim_d    = pick_anim;
            step_d    = '0;
            loop_d    = '0;
            idle_d    = '0;
            pending_d = cand & ~pick_clear;
          end else if (last_step && idle_q == IDLE_LAST) begin
            // Long idle: start sleep exactly as if it had been requested.
            state_d = S_PLAY;
            anim_d  = ANIM_SLEEP;
            step_d  = '0;
            loop_d  = '0;
            idle_d  = '0;
          end else begin
            step_d = last_step ? '0 : step_q + 1'b1;
            if (last_step) idle_d = idle_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (last_step && loop_q == LOOP_LAST) begin
            done_d = 1'b1;
            step_d = '0;
            loop_d = '0;
            idle_d = '0;
            if (pick_valid) begin
              anim_d    = pick_anim;
              pending_d = cand & ~pick_clear;
            end else begin
              state_d = S_IDLE;
              anim_d  = ANIM_IDLE;
            end
          end else begin
            step_d = last_step ? '0 : step_q + 1'b1;
            if (last_step) loop_d = loop_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign anim_sel = anim_q;
  assign step     = step_q;
  assign busy     = (state_q == S_PLAY);
  assign done     = done_q;
  assign pending  = pending_q;

endmodule
